// File: rtl/fetch_if_id.sv
// rtl/fetch_if_id.sv - MIPS fetch stage with PC register, next-PC select and IF/ID pipeline register
module fetch_if_id #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter int          IM_DEPTH   = 4096,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic        exc_d
);

    // First byte address past the instruction memory; 33 bits so the limit never wraps.
    localparam logic [32:0] PC_LIMIT = {1'b0, PC_RESET} + 33'(4 * IM_DEPTH);

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] next_pc;
    logic        fetch_bad;

    // IM is combinational, so the fetch address is simply the PC register.
    assign im_addr   = pc_f;
    assign pc_plus4  = pc_f + 32'd4;
    // Branch target is relative to the delay-slot address, i.e. the branch's own PC + 4.
    assign br_target = pc_d + 32'd4 + (br_offset << 2);

    // Flag fetches from misaligned or out-of-range PCs; the word read there is discarded.
    always_comb begin
        fetch_bad = (pc_f[1:0] != 2'b00)
                  | (pc_f < PC_RESET)
                  | ({1'b0, pc_f} >= PC_LIMIT);
    end

    // Select the next PC; redirects only count when decode holds a real instruction.
    always_comb begin
        next_pc = pc_plus4;
        if (valid_d) begin
            case (npc_sel)
                2'b01:   if (br_taken) next_pc = br_target;
                2'b10:   next_pc = {pc_d[31:28], j_index, 2'b00};
                2'b11:   next_pc = jr_target;
                default: next_pc = pc_plus4;
            endcase
        end
    end

    // PC and IF/ID register: flush beats stall, stall freezes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f    <= PC_RESET;
            instr_d <= 32'd0;
            pc_d    <= 32'd0;
            pc8_d   <= 32'd8;
            valid_d <= 1'b0;
            exc_d   <= 1'b0;
        end else if (flush) begin
            pc_f    <= EXC_VECTOR;
            instr_d <= 32'd0;
            pc_d    <= pc_f;
            pc8_d   <= pc_f + 32'd8;
            valid_d <= 1'b0;
            exc_d   <= 1'b0;
        end else if (!stall) begin
            pc_f    <= next_pc;
            instr_d <= fetch_bad ? 32'd0 : im_rdata;
            pc_d    <= pc_f;
            pc8_d   <= pc_f + 32'd8;
            valid_d <= 1'b1;
            exc_d   <= fetch_bad;
        end
    end

endmodule

// File: tb/tb_fetch_if_id.sv
// tb/tb_fetch_if_id.sv - directed and randomized checks of fetch_if_id against a behavioural model
module tb_fetch_if_id;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam logic [31:0] EVEC  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] br_offset;
    logic [25:0] j_index;
    logic [31:0] jr_target;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic        exc_d;

    logic [31:0] mem [DEPTH];

    // Model state: what the fetch PC and IF/ID latch should hold.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic        m_valid;
    logic        m_exc;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    fetch_if_id #(
        .PC_RESET   (BASE),
        .IM_DEPTH   (DEPTH),
        .EXC_VECTOR (EVEC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .npc_sel   (npc_sel),
        .br_taken  (br_taken),
        .br_offset (br_offset),
        .j_index   (j_index),
        .jr_target (jr_target),
        .im_addr   (im_addr),
        .im_rdata  (im_rdata),
        .pc_f      (pc_f),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .pc8_d     (pc8_d),
        .valid_d   (valid_d),
        .exc_d     (exc_d)
    );

    always #5 clk = ~clk;

    function automatic logic legal_pc(input logic [31:0] a);
        return (a % 4 == 0) && (a >= BASE) && (a < BASE + 4 * DEPTH);
    endfunction

    // Instruction memory; outside the legal window it returns junk that must never reach IF/ID.
    function automatic logic [31:0] im_word(input logic [31:0] a);
        if (legal_pc(a)) return mem[(a - BASE) / 4];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign im_rdata = im_word(im_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc_f"},    pc_f,    m_pc);
        chk({tag, ".im_addr"}, im_addr, m_pc);
        chk({tag, ".instr_d"}, instr_d, m_instr);
        chk({tag, ".pc_d"},    pc_d,    m_pcd);
        chk({tag, ".pc8_d"},   pc8_d,   m_pcd + 32'd8);
        chk({tag, ".valid_d"}, 32'(valid_d), 32'(m_valid));
        chk({tag, ".exc_d"},   32'(exc_d),   32'(m_exc));
    endtask

    task automatic idle_inputs();
        stall     = 1'b0;
        flush     = 1'b0;
        npc_sel   = 2'b00;
        br_taken  = 1'b0;
        br_offset = 32'd0;
        j_index   = 26'd0;
        jr_target = 32'd0;
    endtask

    // Reset is pulled low between edges; outputs must reflect it without waiting for a clock.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        m_pc = BASE; m_instr = 32'd0; m_pcd = 32'd0; m_valid = 1'b0; m_exc = 1'b0;
        check_all(tag);
        idle_inputs();
        #2;
        reset = 1'b1;
    endtask

    // One clock edge: derive the expected result from the architectural rules, then compare.
    task automatic tick(input string tag);
        logic [31:0] target;
        logic        bad;
        target = m_pc + 4;
        if (m_valid) begin
            if (npc_sel == 2'd1 && br_taken) target = m_pcd + 4 + br_offset * 4;
            if (npc_sel == 2'd2)             target = {m_pcd[31:28], j_index, 2'b00};
            if (npc_sel == 2'd3)             target = jr_target;
        end
        bad = !legal_pc(m_pc);
        @(posedge clk);
        #1;
        if (flush) begin
            m_pcd = m_pc; m_pc = EVEC; m_instr = 32'd0; m_valid = 1'b0; m_exc = 1'b0;
        end else if (!stall) begin
            m_instr = bad ? 32'd0 : im_word(m_pc);
            m_pcd   = m_pc;
            m_pc    = target;
            m_valid = 1'b1;
            m_exc   = bad;
        end
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        reset = 1'b0;
        idle_inputs();
        m_pc = BASE; m_instr = 32'd0; m_pcd = 32'd0; m_valid = 1'b0; m_exc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) tick("warm");

        // Mid-run reset, then straight-line fetch.
        do_reset("rst");
        chk("rst.im_addr_const", im_addr, 32'h3000);
        tick("line0");
        chk("line0.instr", instr_d, mem[0]);
        chk("line0.pc_d",  pc_d,    32'h3000);
        chk("line0.pc8_d", pc8_d,   32'h3008);
        chk("line0.valid", 32'(valid_d), 32'd1);
        chk("line0.pc_f",  pc_f,    32'h3004);
        tick("line1");
        chk("line1.pc_f", pc_f, 32'h3008);
        tick("line2");
        chk("line2.pc_f", pc_f, 32'h300C);
        chk("line2.pc_d", pc_d, 32'h3008);
        tick("line3");
        chk("line3.pc_f", pc_f, 32'h3010);

        // Taken backward branch at 0x3008: delay slot fetched, then redirect to 0x3004.
        do_reset("rst_b");
        repeat (3) tick("pre_b");
        npc_sel = 2'd1; br_taken = 1'b1; br_offset = 32'hFFFF_FFFE;
        tick("beq_t");
        chk("beq_t.pc_f", pc_f, 32'h3004);
        chk("beq_t.pc_d", pc_d, 32'h300C);

        do_reset("rst_nb");
        repeat (3) tick("pre_nb");
        npc_sel = 2'd1; br_taken = 1'b0; br_offset = 32'hFFFF_FFFE;
        tick("beq_n");
        chk("beq_n.pc_f", pc_f, 32'h3010);

        // Stall while a jump is presented, then take it exactly once; then a misaligned jr.
        do_reset("rst_j");
        npc_sel = 2'd0;
        repeat (2) tick("pre_j");
        npc_sel = 2'd2; j_index = 26'(32'h3020 >> 2); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            chk("stall.pc_f", pc_f, 32'h3008);
            chk("stall.pc_d", pc_d, 32'h3004);
        end
        stall = 1'b0;
        tick("jump");
        chk("jump.pc_f", pc_f, 32'h3020);
        chk("jump.pc_d", pc_d, 32'h3008);
        npc_sel = 2'd0;
        tick("after_j");
        chk("after_j.pc_f", pc_f, 32'h3024);
        npc_sel = 2'd3; jr_target = 32'h3002;
        tick("jr");
        chk("jr.pc_f", pc_f, 32'h3002);
        npc_sel = 2'd0;
        tick("misal");
        chk("misal.exc",   32'(exc_d),   32'd1);
        chk("misal.instr", instr_d,      32'd0);
        chk("misal.valid", 32'(valid_d), 32'd1);

        // Flush wins over stall.
        stall = 1'b1; flush = 1'b1;
        tick("flush");
        chk("flush.pc_f",  pc_f,         32'h4180);
        chk("flush.valid", 32'(valid_d), 32'd0);
        chk("flush.instr", instr_d,      32'd0);
        stall = 1'b0; flush = 1'b0;
        tick("post_fl");

        // Run off the end of instruction memory.
        do_reset("rst_end");
        for (int i = 0; i < DEPTH; i++) tick("walk");
        chk("walk.pc_f", pc_f, BASE + 4 * DEPTH);
        chk("walk.exc",  32'(exc_d), 32'd0);
        tick("end");
        chk("end.exc",   32'(exc_d),   32'd1);
        chk("end.instr", instr_d,      32'd0);
        chk("end.valid", 32'(valid_d), 32'd1);

        // Randomized traffic against the model.
        do_reset("rst_rnd");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset("rnd_rst");
            end else begin
                stall     = ($urandom_range(4) == 0);
                flush     = ($urandom_range(29) == 0);
                npc_sel   = 2'($urandom_range(3));
                br_taken  = 1'($urandom_range(1));
                br_offset = 32'($urandom_range(16)) - 32'd8;
                j_index   = 26'((32'h3000 + 32'($urandom_range(70)) * 4) >> 2);
                jr_target = 32'h3000 + 32'($urandom_range(280));
                tick("rnd");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
